mac_tile_ml: RTL and testbench

Multi-lane, parametrised successor to the single-lane systolic MAC tile. One tile holds `lanes` weight/partial-sum channels that share one west activation stream. It supports weight-stationary (WS) and output-stationary (OS) dataflow, selected per cycle by `inst_w[2]`. Added over the single-lane tile:
- sequential multi-weight kernel loading under a load FSM;
- a synchronous weight clear;
- per-lane overflow flags;
- optional saturating accumulation.

---
 rtl/mac_tile_ml_if.sv | 27 ++
 rtl/mac_tile_ml.sv | 121 ++++++++++++
 tb/tb_mac_tile_ml.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/mac_tile_ml_if.sv
// Bundled west/north/east/south signals of one mac_tile_ml tile.
// The master drives activations, instructions and north psums; the slave is the tile.
interface mac_tile_ml_if #(
  parameter int bw      = 4,
  parameter int psum_bw = 16,
  parameter int lanes   = 2
);
  logic [bw-1:0]            in_w;
  logic [bw-1:0]            out_e;
  logic [2:0]               inst_w;
  logic [2:0]               inst_e;
  logic                     wclr;
  logic [lanes*psum_bw-1:0] in_n;
  logic [lanes*psum_bw-1:0] out_s;
  logic                     load_done;
  logic [lanes-1:0]         ovf;

  modport master (
    output in_w, inst_w, wclr, in_n,
    input  out_e, inst_e, out_s, load_done, ovf
  );

  modport slave (
    input  in_w, inst_w, wclr, in_n,
    output out_e, inst_e, out_s, load_done, ovf
  );
endinterface

// File: rtl/mac_tile_ml.sv
// Multi-lane WS/OS systolic MAC tile with sequential kernel load FSM and per-lane overflow.
// Define MAC_TILE_SAT_EN to clamp OS accumulation on overflow instead of wrapping.
//
// state     | meaning
// S_EMPTY   | no weights captured, ld_cnt = 0
// S_LOADING | some weights captured, ld_cnt = next lane to fill
// S_FULL    | all lanes hold a weight, load pulses pass east
module mac_tile_ml #(
  parameter int bw      = 4,
  parameter int psum_bw = 16,
  parameter int lanes   = 2
) (
  input logic            clk,
  input logic            reset,
  mac_tile_ml_if.slave   bus
);

  typedef enum logic [1:0] {S_EMPTY, S_LOADING, S_FULL} ld_state_e;

  localparam int CW = (lanes > 1) ? $clog2(lanes) : 1;

  ld_state_e                  state_q;
  logic [CW-1:0]              ld_cnt_q;
  logic [bw-1:0]              a_q;
  logic [bw-1:0]              b_q   [lanes];
  logic signed [psum_bw-1:0]  c_q   [lanes];
  logic [2:0]                 inst_q;
  logic [lanes-1:0]           ovf_q;

  logic signed [psum_bw-1:0]  prod  [lanes];
  logic signed [psum_bw-1:0]  mac   [lanes];
  logic signed [psum_bw-1:0]  acc_d [lanes];
  logic [lanes-1:0]           mac_ovf;

`ifdef MAC_TILE_SAT_EN
  localparam logic signed [psum_bw-1:0] SAT_MAX = {1'b0, {(psum_bw-1){1'b1}}};
  localparam logic signed [psum_bw-1:0] SAT_MIN = {1'b1, {(psum_bw-1){1'b0}}};
`endif

  // a is unsigned, b is two's complement; both widened to psum_bw before the multiply.
  always_comb begin
    for (int l = 0; l < lanes; l++) begin
      prod[l] = $signed({{(psum_bw-bw){1'b0}}, a_q}) *
                $signed({{(psum_bw-bw){b_q[l][bw-1]}}, b_q[l]});
      mac[l]  = c_q[l] + prod[l];
      mac_ovf[l] = (c_q[l][psum_bw-1] == prod[l][psum_bw-1]) &&
                   (mac[l][psum_bw-1] != c_q[l][psum_bw-1]);
`ifdef MAC_TILE_SAT_EN
      if (mac_ovf[l]) acc_d[l] = c_q[l][psum_bw-1] ? SAT_MIN : SAT_MAX;
      else            acc_d[l] = mac[l];
`else
      acc_d[l] = mac[l];
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_EMPTY;
      ld_cnt_q <= '0;
      a_q      <= '0;
      inst_q   <= '0;
      ovf_q    <= '0;
      for (int l = 0; l < lanes; l++) begin
        b_q[l] <= '0;
        c_q[l] <= '0;
      end
    end else if (bus.inst_w[2]) begin
      inst_q   <= bus.inst_w;
      state_q  <= S_EMPTY;
      ld_cnt_q <= '0;
      if (|bus.inst_w[1:0]) a_q <= bus.in_w;
      for (int l = 0; l < lanes; l++) begin
        if (bus.inst_w[1]) b_q[l] <= bus.in_n[l*psum_bw +: bw];
        // Flush beats a pending accumulate from the previous execute.
        if (bus.inst_w[0]) begin
          c_q[l]   <= bus.in_n[l*psum_bw +: psum_bw];
          ovf_q[l] <= 1'b0;
        end else if (inst_q[1]) begin
          c_q[l] <= acc_d[l];
          if (mac_ovf[l]) ovf_q[l] <= 1'b1;
        end
      end
    end else begin
      inst_q[2:1] <= bus.inst_w[2:1];
      inst_q[0]   <= (state_q == S_FULL) && !bus.wclr && bus.inst_w[0];
      if (|bus.inst_w[1:0]) begin
        a_q <= bus.in_w;
        for (int l = 0; l < lanes; l++) c_q[l] <= bus.in_n[l*psum_bw +: psum_bw];
      end
      if (bus.wclr) begin
        state_q  <= S_EMPTY;
        ld_cnt_q <= '0;
      end else if (bus.inst_w[0] && (state_q != S_FULL)) begin
        b_q[ld_cnt_q] <= bus.in_w;
        if (ld_cnt_q == CW'(lanes-1)) begin
          state_q  <= S_FULL;
          ld_cnt_q <= '0;
        end else begin
          state_q  <= S_LOADING;
          ld_cnt_q <= ld_cnt_q + 1'b1;
        end
      end
    end
  end

  always_comb begin
    bus.out_s = '0;
    for (int l = 0; l < lanes; l++) begin
      if (!bus.inst_w[2])     bus.out_s[l*psum_bw +: psum_bw] = mac[l];
      else if (bus.inst_w[1]) bus.out_s[l*psum_bw +: psum_bw] = {{(psum_bw-bw){1'b0}}, b_q[l]};
      else                    bus.out_s[l*psum_bw +: psum_bw] = c_q[l];
    end
  end

  assign bus.out_e     = a_q;
  assign bus.inst_e    = inst_q;
  assign bus.load_done = (state_q == S_FULL);
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_mac_tile_ml.sv
// Scoreboard bench for mac_tile_ml (bw=4, psum_bw=16, lanes=2) with an integer reference model.
// Honours MAC_TILE_SAT_EN the same way the design does.
module tb_mac_tile_ml;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mac_tile_ml_if #(.bw(4), .psum_bw(16), .lanes(2)) bus ();
  mac_tile_ml #(.bw(4), .psum_bw(16), .lanes(2)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    int          out_e;
    int          inst_e;
    int          ld;
    int          ovf;
    logic [31:0] out_s;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  // Reference state: plain integers, weights held as signed values.
  int m_a, m_ie, m_loaded;
  int m_b[2];
  int m_c[2];
  int m_ovf[2];

  function automatic int wrap16(int v);
    logic signed [15:0] t;
    t = v[15:0];
    return int'(t);
  endfunction

  function automatic int sext4(int v);
    logic signed [3:0] t;
    t = v[3:0];
    return int'(t);
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_a = 0; m_ie = 0; m_loaded = 0;
    for (int l = 0; l < 2; l++) begin m_b[l] = 0; m_c[l] = 0; m_ovf[l] = 0; end
  endtask

  task automatic model_step(int iw, int inst, int wc, int n0, int n1);
    int n[2];
    int s[2];
    int prev_exec;
    n[0] = wrap16(n0); n[1] = wrap16(n1);
    for (int l = 0; l < 2; l++) s[l] = m_c[l] + m_a * m_b[l];
    prev_exec = (m_ie >> 1) & 1;
    if (inst[2] == 1'b0) begin
      m_ie = (inst & 6) | ((m_loaded == 2 && wc == 0 && inst[0]) ? 1 : 0);
      if ((inst & 3) != 0) begin
        m_a = iw & 15;
        m_c[0] = n[0]; m_c[1] = n[1];
      end
      if (wc != 0) m_loaded = 0;
      else if (inst[0] && m_loaded < 2) begin
        m_b[m_loaded] = sext4(iw);
        m_loaded++;
      end
    end else begin
      m_ie = inst & 7;
      m_loaded = 0;
      if ((inst & 3) != 0) m_a = iw & 15;
      for (int l = 0; l < 2; l++) begin
        if (inst[1]) m_b[l] = sext4(n[l]);
        if (inst[0]) begin
          m_c[l] = n[l]; m_ovf[l] = 0;
        end else if (prev_exec != 0) begin
          if (s[l] > 32767 || s[l] < -32768) m_ovf[l] = 1;
`ifdef MAC_TILE_SAT_EN
          if (s[l] > 32767)       m_c[l] = 32767;
          else if (s[l] < -32768) m_c[l] = -32768;
          else                    m_c[l] = s[l];
`else
          m_c[l] = wrap16(s[l]);
`endif
        end
      end
    end
  endtask

  function automatic exp_t model_out(int inst);
    exp_t e;
    int v[2];
    for (int l = 0; l < 2; l++) begin
      if (inst[2] == 1'b0) v[l] = wrap16(m_c[l] + m_a * m_b[l]);
      else if (inst[1])    v[l] = m_b[l] & 15;
      else                 v[l] = m_c[l];
    end
    e.out_e  = m_a;
    e.inst_e = m_ie;
    e.ld     = (m_loaded == 2) ? 1 : 0;
    e.ovf    = m_ovf[0] | (m_ovf[1] << 1);
    e.out_s  = {v[1][15:0], v[0][15:0]};
    return e;
  endfunction

  // Entered and left at negedge+2; outputs then reflect the edge just taken.
  task automatic cycle(int iw, int inst, int wc, int n0, int n1);
    bus.in_w   = iw[3:0];
    bus.inst_w = inst[2:0];
    bus.wclr   = wc[0];
    bus.in_n   = {n1[15:0], n0[15:0]};
    model_step(iw, inst, wc, n0, n1);
    sb.push_back(model_out(inst));
    @(negedge clk); #2;
  endtask

  task automatic do_reset();
    bus.in_w = '0; bus.inst_w = '0; bus.wclr = 1'b0; bus.in_n = '0;
    reset = 1'b1;
    #1;
    chk("rst_out_e", 32'(bus.out_e), 32'd0);
    chk("rst_inst_e", 32'(bus.inst_e), 32'd0);
    chk("rst_out_s", bus.out_s, 32'd0);
    chk("rst_load_done", 32'(bus.load_done), 32'd0);
    chk("rst_ovf", 32'(bus.ovf), 32'd0);
    model_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk); #2;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("sb_out_e", 32'(bus.out_e), e.out_e);
        chk("sb_inst_e", 32'(bus.inst_e), e.inst_e);
        chk("sb_load_done", 32'(bus.load_done), e.ld);
        chk("sb_ovf", 32'(bus.ovf), e.ovf);
        chk("sb_out_s", bus.out_s, e.out_s);
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic int rnd_psum();
    int r;
    r = int'($urandom_range(0, 5));
    if (r == 0) return 32767 - int'($urandom_range(0, 40));
    if (r == 1) return -32768 + int'($urandom_range(0, 40));
    return wrap16(int'($urandom_range(0, 65535)));
  endfunction

  initial begin : driver
    reset = 1'b1;
    bus.in_w = '0; bus.inst_w = '0; bus.wclr = 1'b0; bus.in_n = '0;
    model_reset();
    @(negedge clk); #2;
    do_reset();

    // Async reset mid-load, then both following pulses are consumed.
    cycle(4, 1, 0, 0, 0);
    do_reset();
    cycle(1, 1, 0, 0, 0);
    chk("t1_inst_e0_first", 32'(bus.inst_e[0]), 32'd0);
    cycle(2, 1, 0, 0, 0);
    chk("t1_inst_e0_second", 32'(bus.inst_e[0]), 32'd0);
    chk("t1_load_done", 32'(bus.load_done), 32'd1);

    // WS load of {5,3}, third pulse passes east.
    cycle(0, 0, 1, 0, 0);
    cycle(3, 1, 0, 0, 0);
    chk("t2_ld_after1", 32'(bus.load_done), 32'd0);
    chk("t2_ie0_after1", 32'(bus.inst_e[0]), 32'd0);
    cycle(5, 1, 0, 0, 0);
    chk("t2_ld_after2", 32'(bus.load_done), 32'd1);
    chk("t2_ie0_after2", 32'(bus.inst_e[0]), 32'd0);
    cycle(0, 1, 0, 0, 0);
    chk("t2_ie0_pass", 32'(bus.inst_e[0]), 32'd1);

    // WS execute: lane0 = 100 + 2*3, lane1 = -7 + 2*5.
    cycle(2, 2, 0, 100, -7);
    chk("t3_out_s", bus.out_s, 32'h0003_006A);

    // wclr beats a simultaneous load pulse; weights stay intact.
    cycle(9, 1, 1, 0, 0);
    chk("t6_load_done", 32'(bus.load_done), 32'd0);
    chk("t6_ie0", 32'(bus.inst_e[0]), 32'd0);
    cycle(1, 2, 0, 0, 0);
    chk("t6_b_kept", bus.out_s, 32'h0005_0003);

    // OS accumulate 4 x (15 * -8).
    cycle(0, 5, 0, 0, 0);
    for (int i = 0; i < 4; i++) cycle(15, 6, 0, 8, 8);
    cycle(0, 4, 0, 0, 0);
    chk("t4_c", bus.out_s, 32'hFE20_FE20);
    chk("t4_ovf", 32'(bus.ovf), 32'd0);

    // OS overflow on lane0, then flush clears the flag.
    cycle(0, 5, 0, 32760, 0);
    cycle(15, 6, 0, 7, 0);
    cycle(0, 4, 0, 0, 0);
`ifdef MAC_TILE_SAT_EN
    chk("t5_c", bus.out_s, 32'h0000_7FFF);
`else
    chk("t5_c", bus.out_s, 32'h0000_8061);
`endif
    chk("t5_ovf_set", 32'(bus.ovf), 32'd1);
    cycle(0, 5, 0, 0, 0);
    chk("t5_ovf_clr", 32'(bus.ovf), 32'd0);

    // Randomised traffic against the model.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 79) == 0) do_reset();
      else cycle(int'($urandom_range(0, 15)), int'($urandom_range(0, 7)),
                 ($urandom_range(0, 9) == 0) ? 1 : 0, rnd_psum(), rnd_psum());
    end

    @(negedge clk); #2;
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
